// File: rtl/group_scan_pkg.sv
// Shared types, default widths and helpers for the group scan request master.
package group_scan_pkg;

  // Transaction sequencing states.
  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    ASSERT,
    HOLD,
    RESP
  } state_t;

  localparam int DEF_NUM_GROUPS  = 4;
  localparam int DEF_ADDR_W      = 20;
  localparam int DEF_DATA_W      = 32;
  localparam int DEF_SETUP_CYC   = 2;
  localparam int DEF_HOLD_CYC    = 2;
  localparam int DEF_TIMEOUT_CYC = 255;

  // Width of the shared SETUP/ASSERT/HOLD down-counter.
  localparam int CNT_W = 8;

  // LSB position of group g's lane in the flattened read-data bus.
  function automatic int lane_lsb(input int group, input int data_w);
    return group * data_w;
  endfunction

endpackage

// File: rtl/group_scan_mux_master.sv
// Initiator on the static scan request bus: one host request at a time is turned
// into a setup / scan_id assert / hold sequence towards the selected group.
//
//  state  | meaning
//  IDLE   | req_ready high, waiting for a host request
//  SETUP  | addr/wdata and wen/ren driven, scan_id still low
//  ASSERT | scan_id[group] high, waiting for static_ready or timeout
//  HOLD   | scan_id low, bus held until hold time done and ready released
//  RESP   | one-cycle resp_valid pulse back to the host
module group_scan_mux_master
  import group_scan_pkg::*;
#(
  parameter int NUM_GROUPS  = DEF_NUM_GROUPS,
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int SETUP_CYC   = DEF_SETUP_CYC,
  parameter int HOLD_CYC    = DEF_HOLD_CYC,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
  parameter int GROUP_W     = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic                         req_write,
  input  logic [GROUP_W-1:0]           req_group,
  input  logic [ADDR_W-1:0]            req_addr,
  input  logic [DATA_W-1:0]            req_wdata,
  output logic                         resp_valid,
  output logic [DATA_W-1:0]            resp_rdata,
  output logic                         resp_err,
  output logic                         static_wen,
  output logic                         static_ren,
  output logic [ADDR_W-1:0]            static_addr,
  output logic [DATA_W-1:0]            static_wdata,
  output logic [NUM_GROUPS-1:0]        scan_id,
  input  logic [NUM_GROUPS-1:0]        static_ready,
  input  logic [NUM_GROUPS*DATA_W-1:0] static_rdata
);

  state_t               state;
  logic [CNT_W-1:0]     cnt;
  logic                 lat_write;
  logic [GROUP_W-1:0]   lat_group;
  logic [DATA_W-1:0]    rdata_q;
  logic                 err_q;

  logic [NUM_GROUPS-1:0] grp_onehot;
  logic                  sel_ready;
  logic [DATA_W-1:0]     sel_rdata;
  logic                  bad_group;

  // Decode the latched group; an out-of-range index decodes to all zeros.
  always_comb begin
    grp_onehot = NUM_GROUPS'(1) << lat_group;
    sel_ready  = |(static_ready & grp_onehot);
  end

  // Pick the selected group's read-data lane.
  always_comb begin
    sel_rdata = '0;
    for (int g = 0; g < NUM_GROUPS; g++) begin
      if (grp_onehot[g]) sel_rdata = static_rdata[lane_lsb(g, DATA_W) +: DATA_W];
    end
  end

  // Requests to a group that does not exist are answered without touching the bus.
  always_comb bad_group = (32'(req_group) >= NUM_GROUPS);

  // Transaction sequencer with registered bus and response outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      lat_write    <= 1'b0;
      lat_group    <= '0;
      rdata_q      <= '0;
      err_q        <= 1'b0;
      req_ready    <= 1'b1;
      resp_valid   <= 1'b0;
      resp_rdata   <= '0;
      resp_err     <= 1'b0;
      static_wen   <= 1'b0;
      static_ren   <= 1'b0;
      static_addr  <= '0;
      static_wdata <= '0;
      scan_id      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            req_ready <= 1'b0;
            lat_write <= req_write;
            lat_group <= req_group;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            if (bad_group) begin
              resp_valid <= 1'b1;
              resp_rdata <= '0;
              resp_err   <= 1'b1;
              state      <= RESP;
            end else begin
              static_addr  <= req_addr;
              static_wdata <= req_wdata;
              static_wen   <= req_write;
              static_ren   <= ~req_write;
              cnt          <= CNT_W'(SETUP_CYC - 1);
              state        <= SETUP;
            end
          end
        end

        SETUP: begin
          if (cnt == '0) begin
            scan_id <= grp_onehot;
            cnt     <= CNT_W'(TIMEOUT_CYC - 1);
            state   <= ASSERT;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        ASSERT: begin
          if (sel_ready || cnt == '0) begin
            scan_id    <= '0;
            static_wen <= 1'b0;
            static_ren <= 1'b0;
            cnt        <= CNT_W'(HOLD_CYC - 1);
            state      <= HOLD;
            if (sel_ready) begin
              if (!lat_write) rdata_q <= sel_rdata;
            end else begin
              err_q <= 1'b1;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        // Ready must drop before leaving so the group's scan_id edge detector re-arms.
        HOLD: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else if (!sel_ready) begin
            resp_valid <= 1'b1;
            resp_rdata <= (lat_write || err_q) ? '0 : rdata_q;
            resp_err   <= err_q;
            state      <= RESP;
          end
        end

        RESP: begin
          resp_valid <= 1'b0;
          req_ready  <= 1'b1;
          state      <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_group_scan_mux_master.sv
// Scoreboard bench for group_scan_mux_master with a simple per-group ready responder.
module tb_group_scan_mux_master;

  localparam int NG = 4;
  localparam int AW = 20;
  localparam int DW = 32;
  localparam int GW = 3;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [GW-1:0]     req_group;
  logic [AW-1:0]     req_addr;
  logic [DW-1:0]     req_wdata;
  logic              resp_valid;
  logic [DW-1:0]     resp_rdata;
  logic              resp_err;
  logic              static_wen;
  logic              static_ren;
  logic [AW-1:0]     static_addr;
  logic [DW-1:0]     static_wdata;
  logic [NG-1:0]     scan_id;
  logic [NG-1:0]     static_ready;
  logic [NG*DW-1:0]  static_rdata;

  group_scan_mux_master #(
    .NUM_GROUPS(NG), .ADDR_W(AW), .DATA_W(DW),
    .SETUP_CYC(2), .HOLD_CYC(2), .TIMEOUT_CYC(255), .GROUP_W(GW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_group(req_group), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .static_wen(static_wen), .static_ren(static_ren),
    .static_addr(static_addr), .static_wdata(static_wdata),
    .scan_id(scan_id), .static_ready(static_ready), .static_rdata(static_rdata)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Read data each group returns on its lane.
  logic [DW-1:0] lane_val [NG];

  typedef struct {
    logic [DW-1:0] rdata;
    logic          err;
  } exp_t;
  exp_t sb[$];
  exp_t cur_e;

  // Scoreboard: compare every response against the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && resp_valid) begin
      if (sb.size() == 0) begin
        chk("resp_unexpected", 1, 0);
      end else begin
        cur_e = sb.pop_front();
        chk("resp_rdata", resp_rdata, cur_e.rdata);
        chk("resp_err", resp_err, cur_e.err);
      end
    end
  end

  // Bus invariants every cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("wen_ren_excl", static_wen & static_ren, 0);
      chk("id_onehot", ($countones(scan_id) <= 1), 1);
    end
  end

  // Minimum scan_id low time between consecutive assertions.
  int  gap = 0;
  int  min_gap = 1000;
  bit  seen_fall = 0;
  bit  id_prev = 0;
  always @(negedge clk) begin
    if (|scan_id) begin
      if (!id_prev && seen_fall && gap < min_gap) min_gap = gap;
      gap = 0;
    end else begin
      if (id_prev) seen_fall = 1;
      gap++;
    end
    id_prev = |scan_id;
  end

  // Ready responder: raise ready rdy_delay cycles into ASSERT (0 = never),
  // release it rdy_extra cycles after scan_id falls.
  int rdy_delay = 1;
  int rdy_extra = 0;
  int a_cnt = 0;
  int d_cnt = 0;
  int act_g = 0;
  bit active = 0;
  initial begin
    static_ready = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        static_ready = '0;
        a_cnt = 0;
        active = 0;
      end else if (|scan_id) begin
        a_cnt++;
        for (int g = 0; g < NG; g++) if (scan_id[g]) act_g = g;
        active = 1;
        d_cnt = rdy_extra;
        if (rdy_delay != 0 && a_cnt == rdy_delay) static_ready[act_g] = 1'b1;
      end else begin
        a_cnt = 0;
        if (active && static_ready != '0) begin
          if (d_cnt == 0) begin
            static_ready = '0;
            active = 0;
          end else begin
            d_cnt--;
          end
        end
      end
    end
  end

  // Observations collected while a transaction runs.
  int            lat;
  int            id_hi;
  logic [NG-1:0] id_or;
  bit            bus_or;
  bit            got_a;
  logic [NG-1:0] a_id;
  logic          a_wen;
  logic          s_wen, s_ren;
  logic [NG-1:0] s_id;
  logic [AW-1:0] s_addr;
  logic [DW-1:0] s_wdata;

  task automatic issue(input logic w, input logic [GW-1:0] g, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic [DW-1:0] exp_rd, input logic exp_err);
    int n;
    exp_t e;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) chk("req_ready_timeout", 0, 1);
    e.rdata = exp_rd;
    e.err   = exp_err;
    sb.push_back(e);
    req_valid = 1'b1;
    req_write = w;
    req_group = g;
    req_addr  = a;
    req_wdata = d;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_resp();
    bit done;
    done = 0;
    lat = 0; id_hi = 0; id_or = '0; bus_or = 0; got_a = 0; a_id = '0; a_wen = 0;
    while (!done && lat < 2000) begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        s_wen = static_wen; s_ren = static_ren; s_id = scan_id;
        s_addr = static_addr; s_wdata = static_wdata;
      end
      if (|scan_id) begin
        id_hi++;
        if (!got_a) begin
          a_id = scan_id;
          a_wen = static_wen;
          got_a = 1;
        end
      end
      id_or = id_or | scan_id;
      if (static_wen || static_ren || (|scan_id)) bus_or = 1;
      if (resp_valid) done = 1;
    end
    if (!done) begin
      chk("resp_timeout", 0, 1);
    end else begin
      @(negedge clk);
      chk("resp_pulse", resp_valid, 0);
    end
  endtask

  initial begin
    int n;
    lane_val[0] = 32'hA0A0_A0A0;
    lane_val[1] = 32'h1111_1111;
    lane_val[2] = 32'h1234_5678;
    lane_val[3] = 32'hCAFE_0003;
    for (int g = 0; g < NG; g++) static_rdata[g*DW +: DW] = lane_val[g];
    rst_n = 1'b0;
    req_valid = 1'b0; req_write = 1'b0; req_group = '0; req_addr = '0; req_wdata = '0;

    repeat (3) @(negedge clk);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_scan_id", scan_id, 0);
    chk("rst_wen_ren", {static_wen, static_ren}, 0);
    chk("rst_addr", static_addr, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_req_ready", req_ready, 1);

    // Write to group 1, ready on the third ASSERT cycle.
    rdy_delay = 3; rdy_extra = 0;
    issue(1'b1, 3'd1, 20'h00010, 32'hDEAD_BEEF, 32'h0, 1'b0);
    chk("wr_busy_ready", req_ready, 0);
    wait_resp();
    chk("wr_setup_wen", s_wen, 1);
    chk("wr_setup_ren", s_ren, 0);
    chk("wr_setup_id", s_id, 0);
    chk("wr_setup_addr", s_addr, 20'h00010);
    chk("wr_setup_wdata", s_wdata, 32'hDEAD_BEEF);
    chk("wr_assert_id", a_id, 4'b0010);
    chk("wr_assert_wen", a_wen, 1);
    chk("wr_id_or", id_or, 4'b0010);
    chk("wr_id_cycles", id_hi, 3);
    chk("wr_latency", lat, 8);

    // Read from group 2, ready immediately: minimum latency.
    rdy_delay = 1;
    issue(1'b0, 3'd2, 20'h00400, 32'h0, lane_val[2], 1'b0);
    wait_resp();
    chk("rd_setup_ren", s_ren, 1);
    chk("rd_setup_addr", s_addr, 20'h00400);
    chk("rd_id_or", id_or, 4'b0100);
    chk("rd_latency", lat, 6);

    // Read from group 0 with ready never asserted.
    rdy_delay = 0;
    issue(1'b0, 3'd0, 20'h00020, 32'h0, 32'h0, 1'b1);
    wait_resp();
    chk("to_id_cycles", id_hi, 255);
    chk("to_id_or", id_or, 4'b0001);

    // Nonexistent group: immediate error, no bus activity.
    rdy_delay = 1;
    issue(1'b0, 3'd5, 20'h00030, 32'h0, 32'h0, 1'b1);
    wait_resp();
    chk("bad_latency", lat, 1);
    chk("bad_bus_quiet", bus_or, 0);

    // Ready held five extra cycles into HOLD delays the response.
    rdy_delay = 1; rdy_extra = 5;
    issue(1'b0, 3'd3, 20'h00040, 32'h0, lane_val[3], 1'b0);
    wait_resp();
    chk("hold_latency", lat, 10);

    // Back-to-back requests.
    rdy_extra = 0;
    issue(1'b1, 3'd2, 20'h00050, 32'h5555_AAAA, 32'h0, 1'b0);
    wait_resp();
    issue(1'b0, 3'd1, 20'h00060, 32'h0, lane_val[1], 1'b0);
    wait_resp();
    chk("b2b_latency", lat, 6);
    chk("id_gap_min", (min_gap >= 2), 1);

    // Reset asserted mid-ASSERT aborts the transaction silently.
    rdy_delay = 0;
    issue(1'b0, 3'd1, 20'h00070, 32'h0, 32'h0, 1'b0);
    n = 0;
    while (scan_id == '0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("abort_reached_assert", scan_id, 4'b0010);
    repeat (3) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_scan_id", scan_id, 0);
    chk("abort_wen_ren", {static_wen, static_ren}, 0);
    chk("abort_resp_valid", resp_valid, 0);
    sb.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_req_ready", req_ready, 1);
    repeat (20) @(negedge clk);

    // Recovery after the aborted transaction.
    rdy_delay = 1;
    issue(1'b0, 3'd3, 20'h00080, 32'h0, lane_val[3], 1'b0);
    wait_resp();
    chk("recover_latency", lat, 6);
    chk("sb_drained", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
